mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Stage directly downstream of the ALU. Accepts executed ops (ALU result plus op code).
//  Resolves set-on-condition ops from the ALU subtraction result into 0/1.
//  Performs data-memory load/store with a req/ack handshake.
//  Presents a registered writeback (rd, data) to the register file, with backpressure.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles in MEM waiting for mem_ack before abort (1..255)
//  RD_W         5    destination register index width
// PORTS
//  clk            in   1     rising-edge clock
//  reset          in   1     reset, synchronous, active-high
//  ex_valid       in   1     execute stage presents an op
//  ex_ready       out  1     stage accepts op this cycle (ex_valid && ex_ready)
//  ex_op          in   6     ALU control code of the op
//  ex_result      in   32    ALU result (address for load/store; value for MOVE/MOVEI)
//  ex_store_data  in   32    store data (op 3)
//  ex_rd          in   RD_W  destination register
//  mem_req        out  1     memory request, held until mem_ack or abort
//  mem_we         out  1     1=store, 0=load; valid while mem_req
//  mem_addr       out  32    word address = latched ex_result
//  mem_wdata      out  32    latched ex_store_data
//  mem_ack        in   1     memory completes access (single-cycle pulse)
//  mem_rdata      in   32    load data, valid with mem_ack
//  mem_err        out  1     1-cycle pulse: misaligned address or timeout
//  wb_valid       out  1     writeback entry valid
//  wb_ready       in   1     register file consumes entry (wb_valid && wb_ready)
//  wb_rd          out  RD_W  writeback register
//  wb_data        out  32    writeback data
// BEHAVIOUR
//  Reset: state=IDLE; ex_ready, mem_req, mem_we, mem_err, wb_valid = 0;
//   mem_addr, mem_wdata, wb_rd, wb_data = 0; timeout counter = 0.
//   Reset aborts any outstanding access and drops a pending wb entry.
//  FSM states: IDLE, MEM.
//  ex_ready = (state==IDLE) && (!wb_valid || wb_ready). Combinational; not asserted in reset.
//  Accept in IDLE, op class:
//   0 NOP         -> no wb entry.
//   3 STORE, 4 LOAD:
//     - ex_result[1:0]!=0 -> mem_err=1 next cycle, no access, no wb, stay IDLE.
//     - else latch addr/wdata/rd, go to MEM, mem_req=1 next cycle (mem_we=1 for STORE).
//   6 SGE, 7 SLE  -> wb_data = {31'b0, ~ex_result[31]}.
//   8 SGT, 9 SLT  -> wb_data = {31'b0,  ex_result[31]}.
//   10 SEQ        -> wb_data = (ex_result==0).
//   11 SNE        -> wb_data = (ex_result!=0).
//   Sign-bit test only; subtraction overflow is ignored by design.
//   All other codes (incl. 5, 16, default) -> wb_data = ex_result.
//  Non-memory wb latency: accept at cycle N -> wb_valid=1 at N+1.
//  wb entry holds stable while wb_valid && !wb_ready.
//  wb entry clears on consume unless a new entry loads the same cycle.
//  MEM state:
//   - mem_req, mem_addr, mem_we, mem_wdata held stable.
//   - Counter increments each cycle without mem_ack.
//   - mem_ack: mem_req=0 next cycle; go IDLE.
//     LOAD -> wb_valid=1, wb_data=mem_rdata, wb_rd=latched rd (next cycle).
//     STORE -> no wb.
//   - Counter reaches MEM_TIMEOUT without ack: mem_req=0, mem_err pulse, no wb, go IDLE.
//   - mem_ack in the same cycle as timeout: ack wins.
//   - mem_ack while not in MEM is ignored.
//  Counter clears on entry to MEM.
//  wb is always empty on MEM entry (guaranteed by ex_ready), so a load ack never collides.
// TESTING
//  1. SLT ex_result=0xFFFF_FFFE, rd=3 -> next cycle wb_valid=1, wb_rd=3, wb_data=1;
//     SGE same value -> wb_data=0.
//  2. LOAD ex_result=0x100; mem_ack after 3 cycles with rdata=0xCAFE_F00D
//     -> mem_req high 3 cycles, mem_we=0, then wb_data=0xCAFE_F00D;
//     ex_ready=0 throughout MEM.
//  3. STORE addr=0x204, data=0x55 -> mem_req=1, mem_we=1, mem_wdata=0x55;
//     after ack no wb_valid; ex_ready=1 next cycle.
//  4. LOAD addr=0x102 -> mem_err pulse 1 cycle, mem_req stays 0, no wb.
//  5. LOAD, no ack (MEM_TIMEOUT=4) -> mem_req drops after 4 cycles, mem_err pulse, no wb.
//  6. ADD result=7 with wb_ready=0 for 5 cycles -> wb holds 7, ex_ready=0;
//     reset asserted mid-MEM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Purpose:
//   Pipeline stage directly downstream of the ALU. It accepts one executed op
//   per handshake and does one of the following:
//     - resolves set-on-condition ops from the ALU subtraction result into 0/1;
//     - performs a data-memory load or store over a req/ack handshake, with
//       misalignment detection and a timeout;
//     - passes every other result through.
//   The result is presented as a registered writeback entry (rd, data) that is
//   held under backpressure from the register file.
//
// Parameters:
//   MEM_TIMEOUT  cycles spent in MEM without mem_ack before the access is
//                aborted (1..255)
//   RD_W         destination register index width
//
// Ports:
//   clk, reset                 rising-edge clock; synchronous active-high reset
//   ex_valid / ex_ready        execute-stage handshake (accept = valid && ready)
//   ex_op                      ALU control code of the op
//   ex_result                  ALU result (address for load/store, value else)
//   ex_store_data              store data
//   ex_rd                      destination register
//   mem_req / mem_ack          data-memory handshake (ack is a 1-cycle pulse)
//   mem_we                     1 = store, 0 = load; valid while mem_req
//   mem_addr / mem_wdata       latched address / store data
//   mem_rdata                  load data, valid with mem_ack
//   mem_err                    1-cycle pulse on misaligned address or timeout
//   wb_valid / wb_ready        writeback handshake to the register file
//   wb_rd / wb_data            writeback register and data
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int MEM_TIMEOUT = 255,
    parameter int RD_W        = 5
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [5:0]      ex_op,
    input  logic [31:0]     ex_result,
    input  logic [31:0]     ex_store_data,
    input  logic [RD_W-1:0] ex_rd,

    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic            mem_err,

    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data
);

    // -----------------------------------------------------------------------
    // Op codes handled specially; everything else passes ex_result through.
    // -----------------------------------------------------------------------
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_SGE   = 6'd6;
    localparam logic [5:0] OP_SLE   = 6'd7;
    localparam logic [5:0] OP_SGT   = 6'd8;
    localparam logic [5:0] OP_SLT   = 6'd9;
    localparam logic [5:0] OP_SEQ   = 6'd10;
    localparam logic [5:0] OP_SNE   = 6'd11;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [31:0]       mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_err_q,   mem_err_d;
    logic [RD_W-1:0]   ld_rd_q,     ld_rd_d;
    logic [7:0]        cnt_q,       cnt_d;
    logic              wb_valid_q,  wb_valid_d;
    logic [RD_W-1:0]   wb_rd_q,     wb_rd_d;
    logic [31:0]       wb_data_q,   wb_data_d;

    logic              accept;
    logic              is_mem_op;
    logic              misaligned;
    logic [7:0]        cnt_inc;
    logic              timeout_hit;

    // -----------------------------------------------------------------------
    // Resolve the writeback value of a non-memory op. The set ops look only
    // at the sign (or zero-ness) of the ALU subtraction; overflow of that
    // subtraction is deliberately not corrected.
    // -----------------------------------------------------------------------
    function automatic logic [31:0] resolve_wb(input logic [5:0]  op,
                                               input logic [31:0] res);
        logic [31:0] val;
        val = res;
        case (op)
            OP_SGE, OP_SLE: val = {31'b0, ~res[31]};
            OP_SGT, OP_SLT: val = {31'b0,  res[31]};
            OP_SEQ:         val = {31'b0, (res == 32'd0)};
            OP_SNE:         val = {31'b0, (res != 32'd0)};
            default:        val = res;
        endcase
        return val;
    endfunction

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    // A new op may only enter when idle and the writeback slot is free (or
    // being drained this cycle). This also guarantees the slot is empty when
    // a load enters MEM, so its ack can always load the slot.
    assign ex_ready = !reset && (state_q == IDLE) && (!wb_valid_q || wb_ready);

    assign accept      = ex_valid && ex_ready;
    assign is_mem_op   = (ex_op == OP_STORE) || (ex_op == OP_LOAD);
    assign misaligned  = (ex_result[1:0] != 2'b00);
    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_C);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case/if tree can leave one unassigned and infer a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_err_d   = 1'b0;
        ld_rd_d     = ld_rd_q;
        cnt_d       = cnt_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;

        // Consume drains the slot; a same-cycle load below overrides this.
        if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mem_op) begin
                        if (misaligned) begin
                            // Reject without touching memory or writeback.
                            mem_err_d = 1'b1;
                        end else begin
                            mem_addr_d  = ex_result;
                            mem_wdata_d = ex_store_data;
                            ld_rd_d     = ex_rd;
                            mem_we_d    = (ex_op == OP_STORE);
                            mem_req_d   = 1'b1;
                            cnt_d       = 8'd0;
                            state_d     = MEM;
                        end
                    end else if (ex_op != OP_NOP) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = resolve_wb(ex_op, ex_result);
                    end
                end
            end

            MEM: begin
                // Ack is checked first so an ack on the timeout cycle wins.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                    if (!mem_we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ld_rd_q;
                        wb_data_d  = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_err_d = 1'b1;
                    cnt_d     = cnt_inc;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Every register is cleared: reset must abort an in-flight access
            // and drop a pending writeback entry, not just return to IDLE.
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_err_q   <= 1'b0;
            ld_rd_q     <= '0;
            cnt_q       <= 8'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_err_q   <= mem_err_d;
            ld_rd_q     <= ld_rd_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_err   = mem_err_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed self-checking bench for mem_wb_stage (MEM_TIMEOUT = 4).
// Inputs are driven 1 time unit after the rising edge; registered outputs are
// checked at that point, combinational ex_ready 1 unit later.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam int RD_W = 5;

    logic            clk;
    logic            reset;
    logic            ex_valid;
    logic            ex_ready;
    logic [5:0]      ex_op;
    logic [31:0]     ex_result;
    logic [31:0]     ex_store_data;
    logic [RD_W-1:0] ex_rd;
    logic            mem_req;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_ack;
    logic [31:0]     mem_rdata;
    logic            mem_err;
    logic            wb_valid;
    logic            wb_ready;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage #(
        .MEM_TIMEOUT (4),
        .RD_W        (RD_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_op         (ex_op),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [5:0] op, input logic [31:0] res,
                            input logic [31:0] sdata, input logic [RD_W-1:0] rd);
        ex_valid      = 1'b1;
        ex_op         = op;
        ex_result     = res;
        ex_store_data = sdata;
        ex_rd         = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({mem_req, mem_we, mem_err, wb_valid, ex_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {mem_req, mem_we, mem_err, wb_valid, ex_ready});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, wb_data} !== 96'd0 || wb_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h wb_data=%h wb_rd=%0d expected all 0",
                     mem_addr, mem_wdata, wb_data, wb_rd);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", ex_ready);
        end
    endtask

    // Back-to-back set/pass-through ops with wb_ready=1: the slot drains and
    // reloads every cycle.
    task automatic test_set_ops();
        logic [5:0]  ops  [7];
        logic [31:0] res  [7];
        logic [31:0] expd [7];
        ops[0] = 6'd9;  res[0] = 32'hFFFF_FFFE; expd[0] = 32'd1;  // SLT neg
        ops[1] = 6'd6;  res[1] = 32'hFFFF_FFFE; expd[1] = 32'd0;  // SGE neg
        ops[2] = 6'd8;  res[2] = 32'h0000_0005; expd[2] = 32'd0;  // SGT pos
        ops[3] = 6'd7;  res[3] = 32'h0000_0000; expd[3] = 32'd1;  // SLE zero
        ops[4] = 6'd10; res[4] = 32'h0000_0000; expd[4] = 32'd1;  // SEQ zero
        ops[5] = 6'd11; res[5] = 32'h0000_0000; expd[5] = 32'd0;  // SNE zero
        ops[6] = 6'd16; res[6] = 32'h8000_1234; expd[6] = 32'h8000_1234;
        wb_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_op(ops[i], res[i], 32'd0, 5'(i + 3));
            #1;
            n_checks++;
            if (ex_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL set_ready[%0d]: got %b expected 1", i, ex_ready);
            end
            step();
            n_checks++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'(i + 3) || wb_data !== expd[i]) begin
                n_fail++;
                $display("FAIL set_wb[%0d]: got v=%b rd=%0d data=%h expected v=1 rd=%0d data=%h",
                         i, wb_valid, wb_rd, wb_data, i + 3, expd[i]);
            end
        end
        // NOP: accepted, produces no entry; pending entry is consumed.
        drive_op(6'd0, 32'h1234_5678, 32'd0, 5'd1);
        step();
        ex_valid = 1'b0;
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_no_wb: got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_load();
        wb_ready = 1'b1;
        drive_op(6'd4, 32'h0000_0100, 32'd0, 5'd7);
        step();
        ex_valid = 1'b1;  // keep offering; must not be accepted in MEM
        ex_op    = 6'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || ex_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL load_mem[%0d]: got req=%b we=%b addr=%h rdy=%b expected req=1 we=0 addr=00000100 rdy=0",
                         c, mem_req, mem_we, mem_addr, ex_ready);
            end
            if (c == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hCAFE_F00D;
            end
            step();
        end
        mem_ack  = 1'b0;
        ex_valid = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL load_wb: got req=%b v=%b rd=%0d data=%h expected req=0 v=1 rd=7 data=cafef00d",
                     mem_req, wb_valid, wb_rd, wb_data);
        end
        step();
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_consumed: got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_store();
        drive_op(6'd3, 32'h0000_0204, 32'h0000_0055, 5'd9);
        step();
        ex_valid = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h204 || mem_wdata !== 32'h55) begin
            n_fail++;
            $display("FAIL store_mem: got req=%b we=%b addr=%h wdata=%h expected req=1 we=1 addr=00000204 wdata=00000055",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_done: got req=%b v=%b rdy=%b expected req=0 v=0 rdy=1",
                     mem_req, wb_valid, ex_ready);
        end
        // Ack outside MEM must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        n_checks++;
        if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got v=%b req=%b expected 0 0", wb_valid, mem_req);
        end
    endtask

    task automatic test_misaligned();
        drive_op(6'd4, 32'h0000_0102, 32'd0, 5'd4);
        step();
        ex_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_err !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_err: got err=%b req=%b v=%b rdy=%b expected err=1 req=0 v=0 rdy=1",
                     mem_err, mem_req, wb_valid, ex_ready);
        end
        step();
        n_checks++;
        if (mem_err !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_pulse: got err=%b req=%b expected 0 0", mem_err, mem_req);
        end
    endtask

    task automatic test_timeout();
        drive_op(6'd4, 32'h0000_0300, 32'd0, 5'd6);
        step();
        ex_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: got req=%b err=%b expected req=1 err=0",
                         c, mem_req, mem_err);
            end
            step();
        end
        n_checks++;
        if (mem_req !== 1'b0 || mem_err !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got req=%b err=%b v=%b expected req=0 err=1 v=0",
                     mem_req, mem_err, wb_valid);
        end
        step();
        n_checks++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got err=%b expected 0", mem_err);
        end
        // Ack on the final (timeout) cycle: ack wins.
        drive_op(6'd4, 32'h0000_0400, 32'd0, 5'd12);
        step();
        ex_valid = 1'b0;
        step();
        step();
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        n_checks++;
        if (mem_err !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL ack_wins: got err=%b v=%b rd=%0d data=%h expected err=0 v=1 rd=12 data=0badf00d",
                     mem_err, wb_valid, wb_rd, wb_data);
        end
        step();
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        drive_op(6'd1, 32'd7, 32'd0, 5'd2);
        step();
        drive_op(6'd1, 32'd99, 32'd0, 5'd5);  // offered but must stall
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (wb_valid !== 1'b1 || wb_data !== 32'd7 || wb_rd !== 5'd2 || ex_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b data=%h rd=%0d rdy=%b expected v=1 data=00000007 rd=2 rdy=0",
                         c, wb_valid, wb_data, wb_rd, ex_ready);
            end
            step();
        end
        ex_valid = 1'b0;
        wb_ready = 1'b1;
        #1;
        n_checks++;
        if (ex_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b expected 1", ex_ready);
        end
        step();
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_consumed: got v=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_reset_mid_mem();
        drive_op(6'd3, 32'h0000_0800, 32'hA5A5_A5A5, 5'd8);
        step();
        ex_valid = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mem_enter: got req=%b expected 1", mem_req);
        end
        reset = 1'b1;
        step();
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_err, wb_valid, ex_ready} !== 5'b0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_mem: got req=%b we=%b err=%b v=%b rdy=%b addr=%h wdata=%h expected all 0",
                     mem_req, mem_we, mem_err, wb_valid, ex_ready, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (ex_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_recover: got rdy=%b req=%b expected 1 0", ex_ready, mem_req);
        end
    endtask

    initial begin
        reset         = 1'b1;
        ex_valid      = 1'b0;
        ex_op         = 6'd0;
        ex_result     = 32'd0;
        ex_store_data = 32'd0;
        ex_rd         = '0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'd0;
        wb_ready      = 1'b1;

        test_reset();
        test_set_ops();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_backpressure();
        test_reset_mid_mem();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
